// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - decode plus DEPTH-stage control pipeline with memory hold and halt tracking
// Optional: define LOAD_USE_STALL_EN to insert a bubble when an instruction consumes the register a stage-1 load writes.
module pipeline_control_unit #(
    parameter int DEPTH     = 3,
    parameter int MEM_STAGE = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] inst,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        flush,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm,
    output logic [3:0]  ex_aluop,
    output logic [1:0]  ex_alusrc,
    output logic        dREN,
    output logic        dWEN,
    output logic        wb_wen,
    output logic [4:0]  wb_reg,
    output logic        wb_memtoreg,
    output logic        stall,
    output logic        imemREN,
    output logic        halt
);
    typedef struct packed {
        logic       wen;
        logic [4:0] wreg;
        logic       memtoreg;
        logic       dren;
        logic       dwen;
        logic       halt;
    } bundle_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B, OP_HALT = 6'h3F;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR = 4'd4, ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8, ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_LUI = 4'd11;

    localparam logic [1:0] SRC_RT = 2'd0, SRC_SEXT = 2'd1, SRC_ZEXT = 2'd2, SRC_SHAMT = 2'd3;

    bundle_t    stage_q [DEPTH];
    bundle_t    stage_d [DEPTH];
    bundle_t    dec;
    logic [3:0] dec_aluop, ex_aluop_q, ex_aluop_d;
    logic [1:0] dec_alusrc, ex_alusrc_q, ex_alusrc_d;
    logic       halt_pending_q, halt_pending_d;
    logic       halt_q, halt_d;
    logic       mem_busy, load_use, accept;
    logic [5:0] opcode, funct;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign imm    = inst[15:0];

    always_comb begin
        dec        = '0;
        dec_aluop  = ALU_NOP;
        dec_alusrc = SRC_RT;
        case (opcode)
            OP_RTYPE: begin
                dec.wen  = 1'b1;
                dec.wreg = inst[15:11];
                case (funct)
                    6'h21:   dec_aluop = ALU_ADD;
                    6'h23:   dec_aluop = ALU_SUB;
                    6'h24:   dec_aluop = ALU_AND;
                    6'h25:   dec_aluop = ALU_OR;
                    6'h26:   dec_aluop = ALU_XOR;
                    6'h27:   dec_aluop = ALU_NOR;
                    6'h2A:   dec_aluop = ALU_SLT;
                    6'h2B:   dec_aluop = ALU_SLTU;
                    6'h00:   begin dec_aluop = ALU_SLL; dec_alusrc = SRC_SHAMT; end
                    6'h02:   begin dec_aluop = ALU_SRL; dec_alusrc = SRC_SHAMT; end
                    // JR and unknown functs carry no writeback; JR is resolved outside this block
                    default: begin dec.wen = 1'b0; dec.wreg = 5'd0; end
                endcase
            end
            OP_ADDIU: begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_ADD;  dec_alusrc = SRC_SEXT; end
            OP_SLTI:  begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_SLT;  dec_alusrc = SRC_SEXT; end
            OP_SLTIU: begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_SLTU; dec_alusrc = SRC_SEXT; end
            OP_ANDI:  begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_AND;  dec_alusrc = SRC_ZEXT; end
            OP_ORI:   begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_OR;   dec_alusrc = SRC_ZEXT; end
            OP_XORI:  begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_XOR;  dec_alusrc = SRC_ZEXT; end
            OP_LUI:   begin dec.wen = 1'b1; dec.wreg = inst[20:16]; dec_aluop = ALU_LUI;  dec_alusrc = SRC_ZEXT; end
            OP_LW: begin
                dec.wen      = 1'b1;
                dec.wreg     = inst[20:16];
                dec.memtoreg = 1'b1;
                dec.dren     = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_alusrc   = SRC_SEXT;
            end
            OP_SW:         begin dec.dwen = 1'b1; dec_aluop = ALU_ADD; dec_alusrc = SRC_SEXT; end
            OP_BEQ, OP_BNE: dec_aluop = ALU_SUB;
            OP_JAL:        begin dec.wen = 1'b1; dec.wreg = 5'd31; end
            OP_HALT:       dec.halt = 1'b1;
            default:       dec = '0;
        endcase
        if (dec.wreg == 5'd0) begin
            dec.wen = 1'b0;
        end
    end

    assign mem_busy = (stage_q[MEM_STAGE-1].dren | stage_q[MEM_STAGE-1].dwen) & ~dhit;

`ifdef LOAD_USE_STALL_EN
    assign load_use = stage_q[0].dren & (stage_q[0].wreg != 5'd0)
                    & ((stage_q[0].wreg == inst[25:21]) | (stage_q[0].wreg == inst[20:16]));
`else
    assign load_use = 1'b0;
`endif

    // Once a HALT is in flight, nothing further is admitted into stage 1
    assign accept = ihit & ~flush & ~load_use & ~halt_pending_q;

    always_comb begin
        stage_d        = stage_q;
        ex_aluop_d     = ex_aluop_q;
        ex_alusrc_d    = ex_alusrc_q;
        halt_pending_d = halt_pending_q;
        halt_d         = halt_q | stage_q[DEPTH-1].halt;
        if (!mem_busy) begin
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            stage_d[0]     = accept ? dec : '0;
            ex_aluop_d     = accept ? dec_aluop : ALU_NOP;
            ex_alusrc_d    = accept ? dec_alusrc : SRC_RT;
            halt_pending_d = halt_pending_q | (accept & dec.halt);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            ex_aluop_q     <= ALU_NOP;
            ex_alusrc_q    <= SRC_RT;
            halt_pending_q <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            ex_aluop_q     <= ex_aluop_d;
            ex_alusrc_q    <= ex_alusrc_d;
            halt_pending_q <= halt_pending_d;
            halt_q         <= halt_d;
        end
    end

    assign ex_aluop    = ex_aluop_q;
    assign ex_alusrc   = ex_alusrc_q;
    assign dREN        = stage_q[MEM_STAGE-1].dren;
    assign dWEN        = stage_q[MEM_STAGE-1].dwen;
    assign wb_wen      = stage_q[DEPTH-1].wen;
    assign wb_reg      = stage_q[DEPTH-1].wreg;
    assign wb_memtoreg = stage_q[DEPTH-1].memtoreg;
    assign stall       = mem_busy | ~ihit | load_use;
    assign imemREN     = ~halt_pending_q;
    assign halt        = halt_q;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - randomized scoreboard bench for pipeline_control_unit
module tb_pipeline_control_unit;
    localparam int DEPTH     = 3;
    localparam int MEM_STAGE = 2;
    localparam int NCYC      = 4000;

    logic        CLK = 1'b0;
    logic        nRST, ihit, dhit, flush;
    logic [31:0] inst;
    logic [4:0]  rs, rt, wb_reg;
    logic [15:0] imm;
    logic [3:0]  ex_aluop;
    logic [1:0]  ex_alusrc;
    logic        dREN, dWEN, wb_wen, wb_memtoreg, stall, imemREN, halt;

    always #5 CLK = ~CLK;

    pipeline_control_unit #(.DEPTH(DEPTH), .MEM_STAGE(MEM_STAGE)) dut (
        .CLK(CLK), .nRST(nRST), .inst(inst), .ihit(ihit), .dhit(dhit), .flush(flush),
        .rs(rs), .rt(rt), .imm(imm), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .dREN(dREN), .dWEN(dWEN), .wb_wen(wb_wen), .wb_reg(wb_reg), .wb_memtoreg(wb_memtoreg),
        .stall(stall), .imemREN(imemREN), .halt(halt)
    );

    // An accepted instruction and how far it has travelled (1 = EX .. DEPTH = WB)
    typedef struct {
        bit       wen;
        bit [4:0] wreg;
        bit       mtr, dr, dw, hlt, unk;
        int       pos;
    } ent_t;

    typedef struct {
        bit        wen;
        bit [4:0]  wreg;
        bit        mtr, dr, dw, stall, imem, hlt, aluop_zero;
        bit [4:0]  rs, rt;
        bit [15:0] imm;
    } want_t;

    ent_t  inflight[$];
    want_t sb[$];
    bit    m_halt_pending, m_halt;
    int    passed = 0, total = 0;

    logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                                6'h0B, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h03};
    logic [5:0] fn_tab [11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                6'h00, 6'h02, 6'h08};

    function automatic ent_t effect(input logic [31:0] i);
        ent_t e;
        bit [5:0] op, fn;
        e = '{default: 0};
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'h00) begin
            if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02})
                e.wreg = i[15:11];
            e.unk = !(fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h08});
        end else if (op inside {6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) begin
            e.wreg = i[20:16];
        end else if (op == 6'h03) begin
            e.wreg = 5'd31;
        end else begin
            e.unk = !(op inside {6'h02, 6'h04, 6'h05, 6'h2B, 6'h3F});
        end
        e.wen = (e.wreg != 5'd0);
        if (!e.wen) e.wreg = 5'd0;
        e.mtr = (op == 6'h23);
        e.dr  = (op == 6'h23);
        e.dw  = (op == 6'h2B);
        e.hlt = (op == 6'h3F);
        return e;
    endfunction

    function automatic int find(input int p);
        foreach (inflight[i]) if (inflight[i].pos == p) return i;
        return -1;
    endfunction

    function automatic bit m_busy();
        int idx = find(MEM_STAGE);
        return idx >= 0 && (inflight[idx].dr || inflight[idx].dw) && !dhit;
    endfunction

    function automatic bit m_load_use();
`ifdef LOAD_USE_STALL_EN
        int idx = find(1);
        return idx >= 0 && inflight[idx].dr && inflight[idx].wreg != 5'd0 &&
               (inflight[idx].wreg == inst[25:21] || inflight[idx].wreg == inst[20:16]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_halt_pending = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic model_step();
        bit busy, lu;
        int w;
        ent_t e;
        busy = m_busy();
        lu = m_load_use();
        w = find(DEPTH);
        if (w >= 0 && inflight[w].hlt) m_halt = 1'b1;
        if (!busy) begin
            foreach (inflight[i]) inflight[i].pos++;
            for (int i = inflight.size() - 1; i >= 0; i--)
                if (inflight[i].pos > DEPTH) inflight.delete(i);
            if (ihit && !flush && !lu && !m_halt_pending) begin
                e = effect(inst);
                e.pos = 1;
                inflight.push_back(e);
                if (e.hlt) m_halt_pending = 1'b1;
            end
        end
    endtask

    function automatic want_t predict();
        want_t r;
        int wb, mm, ex;
        r = '{default: 0};
        wb = find(DEPTH);
        mm = find(MEM_STAGE);
        ex = find(1);
        if (wb >= 0) begin
            r.wen = inflight[wb].wen;
            r.wreg = inflight[wb].wreg;
            r.mtr = inflight[wb].mtr;
        end
        if (mm >= 0) begin
            r.dr = inflight[mm].dr;
            r.dw = inflight[mm].dw;
        end
        r.aluop_zero = (ex < 0) || inflight[ex].unk;
        r.stall = m_busy() || !ihit || m_load_use();
        r.imem = !m_halt_pending;
        r.hlt = m_halt;
        r.rs = inst[25:21];
        r.rt = inst[20:16];
        r.imm = inst[15:0];
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        r[15:11] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 99);
        if (k < 2) r[31:26] = 6'h3F;
        else if (k < 5) r[31:26] = 6'h3E;
        else r[31:26] = op_tab[$urandom_range(0, 15)];
        if (r[31:26] == 6'h00) r[5:0] = fn_tab[$urandom_range(0, 10)];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, want);
    endtask

    initial begin
        want_t w;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk("wb_wen", 32'(wb_wen), 32'(w.wen));
                chk("wb_reg", 32'(wb_reg), 32'(w.wreg));
                chk("wb_memtoreg", 32'(wb_memtoreg), 32'(w.mtr));
                chk("dREN", 32'(dREN), 32'(w.dr));
                chk("dWEN", 32'(dWEN), 32'(w.dw));
                chk("stall", 32'(stall), 32'(w.stall));
                chk("imemREN", 32'(imemREN), 32'(w.imem));
                chk("halt", 32'(halt), 32'(w.hlt));
                chk("rs", 32'(rs), 32'(w.rs));
                chk("rt", 32'(rt), 32'(w.rt));
                chk("imm", 32'(imm), 32'(w.imm));
                if (w.aluop_zero) chk("ex_aluop_bubble", 32'(ex_aluop), 32'd0);
            end
        end
    end

    initial begin
        int halt_cycles;
        bit do_rst;
        nRST = 1'b0;
        inst = 32'd0;
        ihit = 1'b0;
        dhit = 1'b0;
        flush = 1'b0;
        halt_cycles = 0;
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge CLK);
            if (nRST) model_step();
            #1;
            inst = rand_inst();
            ihit = ($urandom_range(0, 99) < 85);
            dhit = ($urandom_range(0, 99) < 50);
            flush = ($urandom_range(0, 99) < 10);
            do_rst = (cyc < 2) || (m_halt && halt_cycles >= 4) || ($urandom_range(0, 199) == 0);
            if (do_rst) begin
                nRST = 1'b0;
                model_reset();
                halt_cycles = 0;
            end else begin
                nRST = 1'b1;
                if (m_halt) halt_cycles++;
            end
            sb.push_back(predict());
        end
        @(posedge CLK);
        @(posedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
